// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencing controller and HI/LO owner for the E-stage
// multiply/divide unit. One issue per start pulse; iterative latency is
// modelled with a down-counter while the result waits in pending registers.
// Optional feature macro: MULDIV_MADD_EN (MADD/MADDU/MSUB/MSUBU accumulate).
module muldiv_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic        mdbusy,
  output logic        md_done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,  OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,  OP_MTHI  = 4'd5, OP_MTLO  = 4'd6, OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,  OP_MSUB  = 4'd9, OP_MSUBU = 4'd10
  } mdop_t;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic        r_pend_wr;

  logic        w_valid, w_long, w_div, w_signed, w_mthi, w_mtlo, w_accept;
  logic [31:0] w_amag, w_bmag, w_quo, w_rem;
  logic [63:0] w_ma, w_mb, w_prod;
  logic [31:0] w_res_hi, w_res_lo;
  logic        w_res_wr;
  logic [4:0]  w_n;
`ifdef MULDIV_MADD_EN
  logic        w_acc, w_acc_sub;
`endif

  // Opcode decode; codes not listed fall through as NONE.
  always_comb begin
    w_valid  = 1'b0;
    w_long   = 1'b0;
    w_div    = 1'b0;
    w_signed = 1'b0;
    w_mthi   = 1'b0;
    w_mtlo   = 1'b0;
`ifdef MULDIV_MADD_EN
    w_acc     = 1'b0;
    w_acc_sub = 1'b0;
`endif
    case (mdop)
      OP_MULT:  begin w_valid = 1'b1; w_long = 1'b1; w_signed = 1'b1; end
      OP_MULTU: begin w_valid = 1'b1; w_long = 1'b1; end
      OP_DIV:   begin w_valid = 1'b1; w_long = 1'b1; w_div = 1'b1; w_signed = 1'b1; end
      OP_DIVU:  begin w_valid = 1'b1; w_long = 1'b1; w_div = 1'b1; end
      OP_MTHI:  begin w_valid = 1'b1; w_mthi = 1'b1; end
      OP_MTLO:  begin w_valid = 1'b1; w_mtlo = 1'b1; end
`ifdef MULDIV_MADD_EN
      OP_MADD:  begin w_valid = 1'b1; w_long = 1'b1; w_acc = 1'b1; w_signed = 1'b1; end
      OP_MADDU: begin w_valid = 1'b1; w_long = 1'b1; w_acc = 1'b1; end
      OP_MSUB:  begin w_valid = 1'b1; w_long = 1'b1; w_acc = 1'b1; w_acc_sub = 1'b1;
                      w_signed = 1'b1; end
      OP_MSUBU: begin w_valid = 1'b1; w_long = 1'b1; w_acc = 1'b1; w_acc_sub = 1'b1; end
`endif
      default:  w_valid = 1'b0;
    endcase
  end

  assign w_accept = reset && start && (r_state == S_IDLE) && w_valid;
  assign w_n      = w_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);

  // One multiplier and one unsigned divider shared by signed and unsigned ops:
  // signed division runs on magnitudes and re-applies signs (truncation toward
  // zero, remainder follows the dividend), which also keeps INT_MIN / -1 defined.
  always_comb begin
    w_ma   = w_signed ? {{32{srca[31]}}, srca} : {32'h0, srca};
    w_mb   = w_signed ? {{32{srcb[31]}}, srcb} : {32'h0, srcb};
    w_prod = w_ma * w_mb;
    w_amag = (w_signed && srca[31]) ? 32'(-srca) : srca;
    w_bmag = (w_signed && srcb[31]) ? 32'(-srcb) : srcb;
    w_quo  = w_amag / w_bmag;
    w_rem  = w_amag % w_bmag;
    if (w_signed && (srca[31] ^ srcb[31])) w_quo = 32'(-w_quo);
    if (w_signed && srca[31])              w_rem = 32'(-w_rem);
  end

  // Result selection for the pending registers; divide by zero writes nothing.
  always_comb begin
    w_res_wr = 1'b1;
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
    if (w_div) begin
      w_res_wr = (srcb != '0);
      w_res_hi = w_rem;
      w_res_lo = w_quo;
    end
`ifdef MULDIV_MADD_EN
    else if (w_acc) begin
      {w_res_hi, w_res_lo} = w_acc_sub ? ({r_hi, r_lo} - w_prod)
                                       : ({r_hi, r_lo} + w_prod);
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and busy/done outputs.
  always_comb begin
    w_state_nxt = r_state;
    mdbusy      = 1'b0;
    md_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        mdbusy = w_accept && w_long;
        if (w_accept && w_long) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        mdbusy  = 1'b1;
        md_done = (r_cnt == 5'd1);
        if (r_cnt == 5'd1) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latency counter and pending result capture at issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else if (w_accept && w_long) begin
      r_cnt     <= w_n;
      r_pend_hi <= w_res_hi;
      r_pend_lo <= w_res_lo;
      r_pend_wr <= w_res_wr;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - 5'd1;
    end
  end

  // HI/LO: direct moves in the issue cycle, pending commit in the last busy cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_accept && w_mthi) begin
      r_hi <= srca;
    end else if (w_accept && w_mtlo) begin
      r_lo <= srca;
    end else if (md_done && r_pend_wr) begin
      r_hi <= r_pend_hi;
      r_lo <= r_pend_lo;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed stimulus with a cycle-numbered reference model of
// the mult/div controller, checked every cycle, plus literal expectations.
module tb_muldiv_ctrl;
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  mdop;
  logic [31:0] srca, srcb;
  logic        mdbusy, md_done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  longint cyc = 0;

  muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop),
    .srca(srca), .srcb(srcb), .mdbusy(mdbusy), .md_done(md_done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_valid(input logic [3:0] op);
`ifdef MULDIV_MADD_EN
    return (op >= 4'd1) && (op <= 4'd10);
`else
    return (op >= 4'd1) && (op <= 4'd6);
`endif
  endfunction

  function automatic logic m_long(input logic [3:0] op);
`ifdef MULDIV_MADD_EN
    return ((op >= 4'd1) && (op <= 4'd4)) || ((op >= 4'd7) && (op <= 4'd10));
`else
    return (op >= 4'd1) && (op <= 4'd4);
`endif
  endfunction

  // Reference model: busy ends at a cycle number; the result lands the cycle after.
  longint      m_busy_end = -1;
  logic        m_pend_wr = 1'b0;
  logic [31:0] m_pend_hi, m_pend_lo;
  logic [31:0] m_hi = '0, m_lo = '0;

  always @(negedge clk) begin
    logic   acc, e_busy, e_done;
    longint as, bs;
    logic [63:0] au, bu, r64;
    acc = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (!reset) begin
      m_busy_end = -1; m_pend_wr = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      if (m_pend_wr && cyc == m_busy_end + 1) begin
        m_hi = m_pend_hi; m_lo = m_pend_lo; m_pend_wr = 1'b0;
      end
      acc    = start && m_valid(mdop) && !(cyc <= m_busy_end);
      e_busy = (cyc <= m_busy_end) || (acc && m_long(mdop));
      e_done = (cyc == m_busy_end);
    end
    chk("mdbusy", {31'b0, mdbusy}, {31'b0, e_busy});
    chk("md_done", {31'b0, md_done}, {31'b0, e_done});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    if (acc) begin
      as = {{32{srca[31]}}, srca}; bs = {{32{srcb[31]}}, srcb};
      au = {32'h0, srca};          bu = {32'h0, srcb};
      r64 = '0;
      m_pend_wr = 1'b1;
      case (mdop)
        4'd1: r64 = as * bs;
        4'd2: r64 = au * bu;
        4'd3: if (srcb == 0) m_pend_wr = 1'b0;
              else r64 = {32'(as % bs), 32'(as / bs)};
        4'd4: if (srcb == 0) m_pend_wr = 1'b0;
              else r64 = {32'(au % bu), 32'(au / bu)};
        4'd5: begin m_hi = srca; m_pend_wr = 1'b0; end
        4'd6: begin m_lo = srca; m_pend_wr = 1'b0; end
        4'd7: r64 = {m_hi, m_lo} + 64'(as * bs);
        4'd8: r64 = {m_hi, m_lo} + au * bu;
        4'd9: r64 = {m_hi, m_lo} - 64'(as * bs);
        default: r64 = {m_hi, m_lo} - au * bu;
      endcase
      if (m_long(mdop)) begin
        m_busy_end = cyc + longint'((mdop == 4'd3 || mdop == 4'd4) ? DC : MC);
        m_pend_hi = r64[63:32]; m_pend_lo = r64[31:0];
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mdop = op; srca = a; srcb = b;
    @(posedge clk); #1;
    start = 1'b0; mdop = '0; srca = '0; srcb = '0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mdop = '0; srca = '0; srcb = '0;
    idle(2);
    chk("rst_busy", {31'b0, mdbusy}, 32'd0);
    chk("rst_done", {31'b0, md_done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    idle(1);

    // MULT -3 * 7
    issue(4'd1, 32'hFFFFFFFD, 32'd7);
    idle(4);
    chk("t1_done", {31'b0, md_done}, 32'd1);
    chk("t1_busy", {31'b0, mdbusy}, 32'd1);
    idle(1);
    chk("t1_busy_off", {31'b0, mdbusy}, 32'd0);
    chk("t1_hi", hi, 32'hFFFFFFFF);
    chk("t1_lo", lo, 32'hFFFFFFEB);

    // MULTU max * max, back-to-back after completion
    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    idle(5);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    // DIVU 100/7
    issue(4'd4, 32'd100, 32'd7);
    idle(9);
    chk("t2_done", {31'b0, md_done}, 32'd1);
    idle(1);
    chk("t2_lo", lo, 32'd14);
    chk("t2_hi", hi, 32'd2);
    // DIV -7/2 and 7/-2
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    idle(10);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_hi", hi, 32'hFFFFFFFF);
    issue(4'd3, 32'd7, 32'hFFFFFFFE);
    idle(10);
    chk("div_negb_lo", lo, 32'hFFFFFFFD);
    chk("div_negb_hi", hi, 32'd1);
    // INT_MIN / -1
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    idle(10);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'd0);

    // MTHI, MTLO, then divide by zero
    issue(4'd5, 32'h1234, 32'd0);
    issue(4'd6, 32'h5678, 32'd0);
    chk("t3_mthi", hi, 32'h1234);
    issue(4'd3, 32'd99, 32'd0);
    idle(9);
    chk("t3_done", {31'b0, md_done}, 32'd1);
    idle(1);
    chk("t3_busy_off", {31'b0, mdbusy}, 32'd0);
    chk("t3_hi", hi, 32'h1234);
    chk("t3_lo", lo, 32'h5678);

    // Reset mid-RUN
    issue(4'd1, 32'd5, 32'd6);
    idle(1);
    reset = 1'b0;
    #1;
    chk("t4_busy", {31'b0, mdbusy}, 32'd0);
    chk("t4_hi", hi, 32'd0);
    chk("t4_lo", lo, 32'd0);
    idle(2);
    reset = 1'b1;
    idle(1);
    issue(4'd2, 32'd2, 32'd3);
    idle(5);
    chk("t4_lo2", lo, 32'd6);
    chk("t4_hi2", hi, 32'd0);

    // start while RUN is ignored
    issue(4'd1, 32'd3, 32'd5);
    idle(1);
    issue(4'd6, 32'hAA, 32'd0);
    idle(3);
    chk("t5_lo", lo, 32'd15);
    chk("t5_hi", hi, 32'd0);

    // undefined opcode
    issue(4'd12, 32'h77, 32'd1);
    idle(1);
    chk("undef_lo", lo, 32'd15);

`ifdef MULDIV_MADD_EN
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFFFFFF, 32'd0);
    issue(4'd8, 32'd1, 32'd1);
    idle(5);
    chk("t6_maddu_hi", hi, 32'd1);
    chk("t6_maddu_lo", lo, 32'd0);
    issue(4'd9, 32'd1, 32'd1);
    idle(5);
    chk("t6_msub_hi", hi, 32'd0);
    chk("t6_msub_lo", lo, 32'hFFFFFFFF);
`else
    issue(4'd7, 32'd1, 32'd1);
    chk("nomadd_busy", {31'b0, mdbusy}, 32'd0);
    idle(6);
    chk("nomadd_lo", lo, 32'd15);
    chk("nomadd_hi", hi, 32'd0);
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
